// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the unified-memory arbiter
//
// Purpose: FSM state and transaction-owner encodings used by mem_arbiter.
// Ports:   none (package).

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/arb_prio_pick.sv
// rtl/arb_prio_pick.sv - combinational winner selection between fetch and data
//
// Purpose: data normally beats fetch, because the data access belongs to the
//          older instruction. When the streak limit is reached and both sides
//          are requesting, fetch wins instead. Grants are one-hot or zero.
// Ports:
//   if_req_i     - fetch request pending
//   d_req_i      - data request pending
//   streak_hit_i - data has won the configured number of contested grants
//   grant_if_o   - fetch wins this arbitration
//   grant_d_o    - data wins this arbitration

module arb_prio_pick (
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic streak_hit_i,
  output logic grant_if_o,
  output logic grant_d_o
);

  always_comb begin
    grant_d_o  = d_req_i && !(streak_hit_i && if_req_i);
    grant_if_o = if_req_i && !grant_d_o;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter for fetch and load/store
//
// Purpose: accepts one fetch and one data request/ack interface, grants one
//          transaction at a time onto a registered variable-latency memory
//          port, and returns ack plus read data to the owner only.
//          Optional fairness is built when ARB_FAIR_EN is defined: a streak
//          counter forces a fetch grant after MAX_DATA_STREAK contested data
//          grants. Without it, data has strict priority.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   if_req/if_addr                   - fetch request and address
//   if_rdata/if_ack                  - fetch data and one-cycle completion
//   d_req/d_we/d_addr/d_wdata/d_wstrb- data request and command
//   d_rdata/d_ack                    - data read data and one-cycle completion
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wstrb              - registered memory command
//   mem_rdata/mem_ack                - memory read data and completion

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack
);

  if (DW != 32) begin : g_dw_check
    $error("mem_arbiter: DW must be 32");
  end
  if (MAX_DATA_STREAK < 1 || MAX_DATA_STREAK > 15) begin : g_streak_check
    $error("mem_arbiter: MAX_DATA_STREAK must be in 1..15");
  end

  arb_state_e      state_q, state_d;
  arb_owner_e      owner_q, owner_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW/8-1:0] mem_wstrb_q, mem_wstrb_d;
  logic            if_ack_q, if_ack_d;
  logic            d_ack_q, d_ack_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;

  logic streak_hit;
  logic grant_if;
  logic grant_d;

  arb_prio_pick u_pick (
    .if_req_i     (if_req),
    .d_req_i      (d_req),
    .streak_hit_i (streak_hit),
    .grant_if_o   (grant_if),
    .grant_d_o    (grant_d)
  );

`ifdef ARB_FAIR_EN
  logic [3:0] streak_q, streak_d;

  assign streak_hit = (streak_q == 4'(MAX_DATA_STREAK));

  // Only contested data grants build the streak; any fetch grant or an
  // uncontested data grant means fetch is not being starved.
  always_comb begin
    streak_d = streak_q;
    if (state_q == IDLE) begin
      if (grant_d) begin
        streak_d = if_req ? streak_q + 4'd1 : 4'd0;
      end else if (grant_if) begin
        streak_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= 4'd0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign streak_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          owner_d     = OWN_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wstrb_d = d_we ? d_wstrb : '0;
          state_d     = BUSY;
        end else if (grant_if) begin
          // Fetch leaves mem_wdata untouched to avoid needless toggling.
          owner_d     = OWN_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wstrb_d = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          // Ack is registered here so it is high for exactly the RESP cycle.
          if (owner_q == OWN_D) begin
            d_rdata_d = mem_rdata;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end
        end
      end
      RESP: begin
        // Requests are not sampled here, so a requester still holding req
        // in its ack cycle cannot be granted twice.
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter

module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic [DW-1:0]   if_rdata;
  logic            if_ack;
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_wstrb;
  logic [DW-1:0]   d_rdata;
  logic            d_ack;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic [DW-1:0]   mem_rdata = '0;
  logic            mem_ack = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AW              (AW),
    .DW              (DW),
    .MAX_DATA_STREAK (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory model: acks after mem_waits wait cycles, driven on the falling edge.
  int          mem_waits = 0;
  logic [31:0] mem_data  = '0;
  int          wcnt      = 0;

  always @(negedge clk) begin
    if (rst || !mem_req) begin
      wcnt    = 0;
      mem_ack = 1'b0;
    end else begin
      mem_ack   = (wcnt == mem_waits);
      mem_rdata = mem_data;
      wcnt++;
    end
  end

  // Monitor: ack pulses, busy cycles and the address of each new grant.
  int          if_acks    = 0;
  int          d_acks     = 0;
  int          req_cycles = 0;
  logic        prev_req   = 1'b0;
  logic [31:0] glog[$];

  always @(negedge clk) begin
    if (if_ack === 1'b1) if_acks++;
    if (d_ack === 1'b1) d_acks++;
    if (mem_req === 1'b1) req_cycles++;
    if (mem_req === 1'b1 && prev_req !== 1'b1) glog.push_back(mem_addr);
    prev_req = mem_req;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int          ia, da, rc, g0;
    logic [31:0] if_wdata;
    logic [31:0] exp_order [6];
    logic [1:0]  held_exp  [5];

    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    if_wdata = '0;
    cyc(); cyc();
    check("rst_mem_ctl", {mem_req, mem_we, mem_wstrb}, 6'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_acks", {if_ack, d_ack}, 2'b00);
    check("rst_rdata", {if_rdata, d_rdata}, 64'h0);
    rst = 1'b0;

    // Single fetch, zero-wait memory
    mem_waits = 0; mem_data = 32'h0050_0093;
    ia = if_acks; da = d_acks; rc = req_cycles;
    if_req = 1'b1; if_addr = 32'h0000_0010;
    cyc();
    check("f_mem_req", mem_req, 1);
    check("f_mem_addr", mem_addr, 32'h10);
    check("f_we_wstrb", {mem_we, mem_wstrb}, 5'b0);
    check("f_early_ack", if_ack, 0);
    cyc();
    check("f_if_ack", if_ack, 1);
    check("f_if_rdata", if_rdata, 32'h0050_0093);
    check("f_mem_req_drop", mem_req, 0);
    check("f_d_rdata_hold", d_rdata, 32'h0);
    if_req = 1'b0;
    cyc();
    check("f_ack_pulse", if_ack, 0);
    cyc();
    check("f_no_d_ack", d_acks - da, 0);
    check("f_req_cycles", req_cycles - rc, 1);
    check("f_if_ack_cnt", if_acks - ia, 1);

    // Store with three wait states
    mem_waits = 3; mem_data = 32'hCAFE_0001;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    cyc();
    check("st_ctl", {mem_req, mem_we, mem_wstrb}, 6'b11_0011);
    check("st_addr", mem_addr, 32'h100);
    check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("st_stable", (mem_req && mem_we && mem_addr == 32'h100 && mem_wdata == 32'hDEAD_BEEF
                          && mem_wstrb == 4'b0011 && !d_ack), 1);
    end
    cyc();
    check("st_d_ack", d_ack, 1);
    check("st_d_rdata", d_rdata, 32'hCAFE_0001);
    check("st_mem_req_drop", mem_req, 0);
    check("st_if_rdata_hold", if_rdata, 32'h0050_0093);
    d_req = 1'b0;
    cyc();
    check("st_ack_pulse", d_ack, 0);

    // Simultaneous fetch and load
    mem_waits = 1; mem_data = 32'hA5A5_0001;
    ia = if_acks; da = d_acks; g0 = glog.size();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
    if_req = 1'b1; if_addr = 32'h20;
    cyc();
    check("s_first_addr", mem_addr, 32'h200);
    check("s_load_wstrb", {mem_we, mem_wstrb}, 5'b0);
    for (int n = 0; n < 30 && (if_req || d_req); n++) begin
      cyc();
      if (mem_req && mem_addr == 32'h20) if_wdata = mem_wdata;
      if (d_ack) d_req = 1'b0;
      if (if_ack) if_req = 1'b0;
    end
    check("s_done", {if_req, d_req}, 2'b00);
    cyc();
    check("s_grants", glog.size() - g0, 2);
    check("s_order0", glog[g0], 32'h200);
    check("s_order1", glog[g0+1], 32'h20);
    check("s_if_ack_cnt", if_acks - ia, 1);
    check("s_d_ack_cnt", d_acks - da, 1);
    check("s_fetch_wdata_kept", if_wdata, 32'h1234_5678);

    // Fetch held while data re-requests back-to-back
`ifdef ARB_FAIR_EN
    exp_order = '{32'h300, 32'h300, 32'h30, 32'h300, 32'h300, 32'h30};
`else
    exp_order = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h300, 32'h300};
`endif
    mem_waits = 0;
    g0 = glog.size();
    if_req = 1'b1; if_addr = 32'h30;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    for (int n = 0; n < 60 && glog.size() < g0 + 6; n++) cyc();
    check("fair_grants", glog.size() >= g0 + 6, 1);
    for (int k = 0; k < 6; k++) check($sformatf("fair_order%0d", k), glog[g0+k], exp_order[k]);
    for (int n = 0; n < 40 && (if_req || d_req); n++) begin
      cyc();
      if (d_ack) d_req = 1'b0;
      if (if_ack) if_req = 1'b0;
    end
    check("fair_drain", {if_req, d_req}, 2'b00);
    cyc(); cyc();

    // Reset while the memory is stalled
    mem_waits = 1000;
    if_req = 1'b1; if_addr = 32'h40;
    cyc();
    check("r_busy", mem_req, 1);
    cyc(); cyc();
    rst = 1'b1; if_req = 1'b0;
    ia = if_acks; da = d_acks;
    cyc();
    check("r_mem_req", mem_req, 0);
    check("r_rdata_clr", {if_rdata, d_rdata}, 64'h0);
    rst = 1'b0; mem_waits = 0;
    repeat (4) cyc();
    check("r_no_ack", (if_acks - ia) + (d_acks - da), 0);
    mem_data = 32'h1111_2222;
    if_req = 1'b1; if_addr = 32'h44;
    cyc();
    check("r_fresh_req", {mem_req, mem_addr}, {1'b1, 32'h44});
    cyc();
    check("r_fresh_ack", if_ack, 1);
    check("r_fresh_rdata", if_rdata, 32'h1111_2222);
    if_req = 1'b0;
    cyc();

    // Fetch held high through its ack: one grant per IDLE visit
    mem_data = 32'h0BAD_F00D;
    ia = if_acks; g0 = glog.size();
    held_exp = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01};
    if_req = 1'b1; if_addr = 32'h50;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check($sformatf("h_step%0d", k), {mem_req, if_ack}, held_exp[k]);
    end
    if_req = 1'b0;
    cyc(); cyc();
    check("h_acks", if_acks - ia, 2);
    check("h_grants", glog.size() - g0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the core's instruction-fetch port and load/store data port. The block takes two independent request/acknowledge interfaces, picks one winner per transaction, and drives a shared variable-latency memory port. It returns the acknowledge and read data to the winner only. It replaces the separate combinational instruction and data memories when the core moves to a unified memory. The core stalls fetch or memory-stage progress for as long as the corresponding acknowledge is low.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width. Must be 32; `DW/8` strobes.
- `MAX_DATA_STREAK`, 4: consecutive contested data grants before fetch is forced. Only used with `ARB_FAIR_EN`; range 1–15.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request, held until `if_ack`.
- `if_addr` in AW: fetch address, stable while `if_req`.
- `if_rdata` out DW: fetch data, valid in `if_ack` cycle.
- `if_ack` out 1: one-cycle completion pulse.
- `d_req` in 1: data request, held until `d_ack`.
- `d_we` in 1: 1 means store, 0 means load.
- `d_addr` in AW: data address.
- `d_wdata` in DW: store data.
- `d_wstrb` in DW/8: byte enables for stores.
- `d_rdata` out DW: load data, valid in `d_ack` cycle.
- `d_ack` out 1: one-cycle completion pulse.
- `mem_req` out 1: memory request, held until `mem_ack`.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` out: registered command fields.
- `mem_rdata` in DW: valid when `mem_ack`=1.
- `mem_ack` in 1: memory completion, any latency ≥0 cycles after `mem_req` rises.

## Operation
- State machine with three states:
  - `IDLE`: sample `if_req` and `d_req`. If either is high, latch the winner's command into the `mem_*` registers, record the owner, and go to `BUSY`.
  - `BUSY`: `mem_req`=1. On `mem_ack`, capture `mem_rdata` into the owner's rdata register, drop `mem_req`, and go to `RESP`.
  - `RESP`: pulse the owner's ack for exactly one cycle, then go to `IDLE`. Requests are ignored in `RESP`, so a requester still holding `req` during its ack cycle is never granted twice.
- Winner selection in `IDLE`:
  - Data beats fetch, because the data access belongs to the older instruction.
  - With only one request, that request wins.
- Command encoding:
  - A fetch drives `mem_we`=0 and `mem_wstrb`=0, and `mem_wdata` keeps its previous value.
  - Loads drive `mem_wstrb`=0.
- Read data:
  - Store completion still pulses `d_ack`, and `d_rdata` is updated with whatever `mem_rdata` carries.
  - A non-owner rdata register holds its value.
- The arbiter performs no address decode, alignment check or bus-error handling.

## Timing
- Minimum latency is request sampled in cycle N → `mem_req` high in N+1 → zero-wait `mem_ack` in N+1 → ack in N+2. That gives at best one transaction per 3 cycles.
- Each extra memory wait cycle adds one cycle of latency.
- `mem_req` and all `mem_*` command fields are stable from the rise of `mem_req` through the `mem_ack` cycle.
- `mem_ack` outside `BUSY` is ignored.
- If `if_req` and `d_req` rise in the same `IDLE` cycle:
  - data is granted first;
  - fetch is granted at the next `IDLE`, provided it is still held.
- Reset:
  - All outputs go to 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `if_ack`, `d_ack`, `if_rdata`, `d_rdata`.
  - State goes to `IDLE` and the streak counter goes to 0.
- Reset mid-transaction aborts it:
  - `mem_req` is low after the reset edge;
  - no ack is issued;
  - the memory is reset by the same `rst`.
- Dropping `req` before ack is a protocol violation; the transaction still completes.

## Configuration
- `ARB_FAIR_EN` defined:
  - A 4-bit streak counter increments on each data grant made while `if_req` is also high.
  - It clears on every fetch grant, and on any uncontested data grant.
  - When streak == `MAX_DATA_STREAK` and both requests are pending, fetch wins.
- `ARB_FAIR_EN` undefined: strict data priority; the counter is not built and `MAX_DATA_STREAK` is ignored.

## Structure
- Package `mem_arb_pkg` holds:
  - the state encoding: `IDLE`=2'd0, `BUSY`=2'd1, `RESP`=2'd2;
  - the owner encoding: `OWN_IF`=1'b0, `OWN_D`=1'b1.
- One combinational sub-module, `arb_prio_pick`, takes `if_req`, `d_req` and the streak-limit flag and returns `grant_if` and `grant_d`, which are one-hot or zero.
- The FSM, command registers and rdata registers stay in `mem_arbiter`.

## Test plan
- **Single fetch.** Drive `if_req` with `if_addr`=0x0000_0010 and a memory that acks in the same cycle with 0x0050_0093. Require `mem_req` high for 1 cycle, `if_ack` 2 cycles after the request is sampled, `if_rdata`=0x0050_0093, and `d_ack` never high.
- **Store with wait states.** Drive `d_req`, `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEAD_BEEF, `d_wstrb`=4'b0011, with 3 memory wait cycles. Require the `mem_*` fields stable for 4 cycles and `d_ack` 5 cycles after sampling.
- **Simultaneous requests.** Raise both in the same cycle, both held. Require data granted first, fetch granted at the next `IDLE`, and exactly one ack pulse each.
- **Fairness on** (`ARB_FAIR_EN`, `MAX_DATA_STREAK`=2). Hold `if_req` with `d_req` re-asserted back-to-back. Require the grant order D, D, IF, D, D, IF. With the macro undefined, IF is never granted while `d_req` is pending.
- **Reset in `BUSY`.** Assert `rst` for 1 cycle while the memory is stalled. Require `mem_req`=0 on the next cycle, no ack, and a fresh `if_req` afterwards completing normally.
- **Held request through ack.** Keep `if_req` high after `if_ack`. Require the next `mem_req` to rise no earlier than 1 cycle after `RESP`, giving exactly 1 grant per `IDLE` visit.
